// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: CPU byte/half/word loads and stores with
// misalignment detection, plus a UART programming port gated by a RUN/PROG mode FSM.
module data_mem_ctrl #(
    parameter int ADDR_W   = 14,
    parameter bit BOOT_RUN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [1:0]          mem_size_i,
    input  logic                mem_unsigned_i,
    input  logic [ADDR_W+1:0]   mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    output logic                mem_ready_o,
    output logic                mem_valid_o,
    output logic                mem_misalign_o,
    output logic [31:0]         mem_rdata_o,
    input  logic                upg_rst_i,
    input  logic                upg_wen_i,
    input  logic [ADDR_W-1:0]   upg_addr_i,
    input  logic [31:0]         upg_data_i,
    input  logic                upg_done_i,
    output logic                kickoff_o,
    output logic [ADDR_W:0]     upg_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = {(ADDR_W+1){1'b1}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {
        ST_PROG = 1'b0,
        ST_RUN  = 1'b1
    } mode_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane so the enables pick the right one.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    mode_t               state_r;
    mode_t               state_nxt_s;
    logic                ready_s;
    logic                run_cond_s;
    logic                accept_s;
    logic                misalign_s;
    logic [ADDR_W-1:0]   port_idx_s;
    logic [3:0]          wr_be_s;
    logic [31:0]         wr_data_s;
    logic [31:0]         mem_array [DEPTH];
    logic [31:0]         rd_word_r;
    logic                valid_r;
    logic                misalign_r;
    logic                load_done_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [1:0]          lane_r;
    logic [31:0]         rdata_hold_r;
    logic [31:0]         rdata_s;
    logic [ADDR_W:0]     cnt_r;

    assign run_cond_s = upg_rst_i | upg_done_i;
    assign accept_s   = mem_req_i & (state_r == ST_RUN);
    assign misalign_s = is_misaligned(mem_size_i, mem_addr_i[1:0]);

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BOOT_RUN ? ST_RUN : ST_PROG;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mode next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN:  state_nxt_s = run_cond_s ? ST_RUN : ST_PROG;
            ST_PROG: state_nxt_s = run_cond_s ? ST_RUN : ST_PROG;
            default: state_nxt_s = ST_PROG;
        endcase
    end

    // Mode-dependent outputs.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_RUN:  ready_s = 1'b1;
            ST_PROG: ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    // Array port ownership: the CPU in RUN, the UPG port in PROG.
    always_comb begin
        port_idx_s = mem_addr_i[ADDR_W+1:2];
        wr_be_s    = 4'b0000;
        wr_data_s  = 32'h0000_0000;
        if (state_r == ST_RUN) begin
            if (accept_s && mem_we_i && !misalign_s) begin
                wr_be_s   = byte_en(mem_size_i, mem_addr_i[1:0]);
                wr_data_s = lane_data(mem_size_i, mem_wdata_i);
            end else begin
                wr_be_s = 4'b0000;
            end
        end else begin
            port_idx_s = upg_addr_i;
            if (upg_wen_i) begin
                wr_be_s   = 4'b1111;
                wr_data_s = upg_data_i;
            end else begin
                wr_be_s = 4'b0000;
            end
        end
    end

    // Synchronous array with per-lane write enables; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        rd_word_r <= mem_array[port_idx_s];
        for (int i = 0; i < 4; i++) begin
            if (wr_be_s[i]) begin
                mem_array[port_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

    // Completion pipeline: request attributes captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= 1'b0;
            misalign_r   <= 1'b0;
            load_done_r  <= 1'b0;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
            lane_r       <= 2'b00;
            rdata_hold_r <= 32'h0000_0000;
        end else begin
            valid_r      <= accept_s;
            misalign_r   <= accept_s & misalign_s;
            load_done_r  <= accept_s & ~mem_we_i & ~misalign_s;
            rdata_hold_r <= rdata_s;
            if (accept_s) begin
                size_r <= mem_size_i;
                uns_r  <= mem_unsigned_i;
                lane_r <= mem_addr_i[1:0];
            end
        end
    end

    // Load result is extended from the freshly read word, otherwise the last result is held.
    always_comb begin
        rdata_s = rdata_hold_r;
        if (load_done_r) begin
            rdata_s = load_ext(rd_word_r, size_r, uns_r, lane_r);
        end else begin
            rdata_s = rdata_hold_r;
        end
    end

    // Programming-session word counter: cleared on entry to PROG, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (state_r == ST_RUN) begin
            if (!run_cond_s) begin
                cnt_r <= {(ADDR_W+1){1'b0}};
            end
        end else if (upg_wen_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign mem_ready_o    = ready_s;
    assign mem_valid_o    = valid_r;
    assign mem_misalign_o = misalign_r;
    assign mem_rdata_o    = rdata_s;
    assign kickoff_o      = state_r;
    assign upg_cnt_o      = cnt_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed steps plus random CPU traffic
// compared against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int AW = 4;
    localparam int NBYTES = 4 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req, we, uns;
    logic [1:0]      size;
    logic [AW+1:0]   addr;
    logic [31:0]     wdata;
    logic            ready, valid, misalign, kickoff;
    logic [31:0]     rdata;
    logic            upg_rst, upg_wen, upg_done;
    logic [AW-1:0]   upg_addr;
    logic [31:0]     upg_data;
    logic [AW:0]     cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [NBYTES];
    bit          m_run;
    int          m_cnt;
    logic [31:0] m_rdata;
    bit          m_valid, m_mis;

    data_mem_ctrl #(.ADDR_W(AW), .BOOT_RUN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_i(req), .mem_we_i(we), .mem_size_i(size), .mem_unsigned_i(uns),
        .mem_addr_i(addr), .mem_wdata_i(wdata),
        .mem_ready_o(ready), .mem_valid_o(valid), .mem_misalign_o(misalign), .mem_rdata_o(rdata),
        .upg_rst_i(upg_rst), .upg_wen_i(upg_wen), .upg_addr_i(upg_addr), .upg_data_i(upg_data),
        .upg_done_i(upg_done), .kickoff_o(kickoff), .upg_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one rising edge, from the pre-edge inputs.
    task automatic model_edge();
        int a, n;
        logic [31:0] v;
        m_valid = req && m_run;
        m_mis = 1'b0;
        if (m_valid) begin
            a = int'(addr);
            n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            m_mis = (a % n) != 0;
            if (!m_mis) begin
                if (we) begin
                    for (int k = 0; k < n; k++) ref_mem[a+k] = wdata[8*k +: 8];
                end else begin
                    v = 32'h0;
                    for (int k = 0; k < n; k++) v = v | ({24'h0, ref_mem[a+k]} << (8*k));
                    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                    m_rdata = v;
                end
            end
        end
        if (!m_run && upg_wen) begin
            for (int k = 0; k < 4; k++) ref_mem[int'(upg_addr)*4+k] = upg_data[8*k +: 8];
            if (m_cnt < (1 << (AW+1)) - 1) m_cnt++;
        end
        if (m_run && !(upg_rst || upg_done)) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run && (upg_rst || upg_done)) begin
            m_run = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", {31'h0, valid}, {31'h0, m_valid});
        chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
        chk("rdata", rdata, m_rdata);
        chk("kickoff", {31'h0, kickoff}, {31'h0, m_run});
        chk("ready", {31'h0, ready}, {31'h0, m_run});
        chk("upg_cnt", {27'h0, cnt}, 32'(m_cnt));
    endtask

    task automatic cpu(input logic w, input logic [1:0] s, input logic u,
                       input logic [AW+1:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        tick();
        req = 1'b0;
    endtask

    task automatic upg_write(input logic [AW-1:0] a, input logic [31:0] d);
        upg_wen = 1'b1; upg_addr = a; upg_data = d;
        tick();
        upg_wen = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = 32'h0;
        upg_rst = 1'b0; upg_wen = 1'b0; upg_done = 1'b0; upg_addr = '0; upg_data = 32'h0;
        m_run = 1'b0; m_cnt = 0; m_rdata = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        #12;
        chk("rst_kickoff", {31'h0, kickoff}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cnt", {27'h0, cnt}, 32'h0);
        rst_n = 1'b1;

        // PROG: preload through the UPG port.
        upg_write(4'd0, 32'h1111_1111);
        upg_write(4'd1, 32'h2222_2222);
        upg_write(4'd2, 32'h3333_3333);
        chk("cnt3", {27'h0, cnt}, 32'd3);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 6'h00;
        for (int i = 3; i < 16; i++) upg_write(AW'(i), $urandom);
        req = 1'b0;
        for (int i = 0; i < 20; i++) upg_write(AW'($urandom_range(3, 15)), $urandom);
        chk("cnt_sat", {27'h0, cnt}, 32'd31);
        upg_done = 1'b1;
        upg_write(4'd15, 32'h5A5A_A5A5);
        chk("kickoff_run", {31'h0, kickoff}, 32'h1);

        // RUN: directed accesses.
        cpu(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
        chk("lw_08", rdata, 32'h3333_3333);
        cpu(1'b0, 2'b10, 1'b0, 6'h3C, 32'h0);
        chk("lw_3c_lastupg", rdata, 32'h5A5A_A5A5);
        cpu(1'b1, 2'b10, 1'b0, 6'h10, 32'h0000_0000);
        cpu(1'b1, 2'b00, 1'b0, 6'h11, 32'h0000_0080);
        cpu(1'b0, 2'b00, 1'b0, 6'h11, 32'h0);
        chk("lb_11", rdata, 32'hFFFF_FF80);
        cpu(1'b0, 2'b00, 1'b1, 6'h11, 32'h0);
        chk("lbu_11", rdata, 32'h0000_0080);
        cpu(1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        chk("lw_10a", rdata, 32'h0000_8000);
        cpu(1'b1, 2'b01, 1'b0, 6'h12, 32'h0000_BEEF);
        cpu(1'b0, 2'b01, 1'b0, 6'h12, 32'h0);
        chk("lh_12", rdata, 32'hFFFF_BEEF);
        cpu(1'b0, 2'b01, 1'b0, 6'h11, 32'h0);
        chk("lh_11_mis", {31'h0, misalign}, 32'h1);
        chk("lh_11_hold", rdata, 32'hFFFF_BEEF);
        cpu(1'b1, 2'b10, 1'b0, 6'h12, 32'hDEAD_DEAD);
        chk("sw_12_mis", {31'h0, misalign}, 32'h1);
        cpu(1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        chk("lw_10b", rdata, 32'hBEEF_8000);
        cpu(1'b1, 2'b10, 1'b0, 6'h20, 32'hCAFE_F00D);
        chk("b2b_sw_valid", {31'h0, valid}, 32'h1);
        cpu(1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
        chk("b2b_lw_valid", {31'h0, valid}, 32'h1);
        chk("b2b_lw", rdata, 32'hCAFE_F00D);
        tick();

        // RUN: random back-to-back traffic; UPG writes must be ignored.
        for (int i = 0; i < 400; i++) begin
            req = 1'($urandom); we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
            addr = 6'($urandom); wdata = $urandom;
            upg_wen = 1'($urandom); upg_addr = AW'($urandom); upg_data = $urandom;
            tick();
        end
        req = 1'b0; upg_wen = 1'b0;

        // Leave RUN on the same edge a load is accepted.
        upg_done = 1'b0; upg_rst = 1'b1;
        tick();
        upg_rst = 1'b0;
        cpu(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
        chk("switch_valid", {31'h0, valid}, 32'h1);
        chk("switch_ready", {31'h0, ready}, 32'h0);
        chk("switch_cnt", {27'h0, cnt}, 32'h0);
        cpu(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
        chk("prog_no_valid", {31'h0, valid}, 32'h0);
        upg_write(4'd7, 32'h0BAD_F00D);
        chk("prog_cnt1", {27'h0, cnt}, 32'h1);
        upg_done = 1'b1;
        upg_write(4'd6, 32'h1234_5678);
        cpu(1'b0, 2'b10, 1'b0, 6'h18, 32'h0);
        chk("edge_upg_write", rdata, 32'h1234_5678);
        cpu(1'b0, 2'b01, 1'b1, 6'h1E, 32'h0);
        chk("lhu_1e", rdata, 32'h0000_0BAD);

        // Asynchronous reset in the middle of traffic.
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 6'h1C;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, valid}, 32'h0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_kickoff", {31'h0, kickoff}, 32'h0);
        chk("mid_rst_ready", {31'h0, ready}, 32'h0);
        chk("mid_rst_cnt", {27'h0, cnt}, 32'h0);
        m_run = 1'b0; m_cnt = 0; m_rdata = 32'h0;
        #10;
        rst_n = 1'b1;
        upg_done = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory controller for the CPU data path with a single clock domain. It supports byte, half-word and word loads and stores with sign or zero extension, and detects misaligned accesses. Loads are registered with a one-cycle valid handshake. A UART programming (UPG) port shares the same clock, and a registered RUN/PROG mode state machine arbitrates between that port and the CPU port.

## Interface
Parameters:
- `ADDR_W`, 14: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `BOOT_RUN`, 1: mode after reset; 1 = RUN, 0 = PROG.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req_i`  in  1  CPU access request; accepted when `mem_ready_o`=1.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_unsigned_i`  in  1  load zero-extends when 1, sign-extends when 0.
- `mem_addr_i`  in  ADDR_W+2  byte address; bits [1:0] select the lane.
- `mem_wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `mem_ready_o`  out  1  1 in RUN, 0 in PROG.
- `mem_valid_o`  out  1  one-cycle completion pulse.
- `mem_misalign_o`  out  1  qualifies `mem_valid_o`: the access was misaligned and dropped.
- `mem_rdata_o`  out  32  extended load result; holds its value until the next load completes.
- `upg_rst_i`  in  1  UPG reset, active-high; 1 = UART programming idle.
- `upg_wen_i`  in  1  UPG word write enable.
- `upg_addr_i`  in  ADDR_W  UPG word address.
- `upg_data_i`  in  32  UPG write data.
- `upg_done_i`  in  1  1 = programming finished.
- `kickoff_o`  out  1  registered mode; 1 = RUN.
- `upg_cnt_o`  out  ADDR_W+1  words written in the current PROG session; saturates at all-ones.

## Operation
- Reset (async, `rst_n`=0):
  - `kickoff_o`=BOOT_RUN.
  - `mem_valid_o`=0, `mem_misalign_o`=0, `mem_rdata_o`=0, `upg_cnt_o`=0.
  - Array contents are not reset.
- Mode FSM (states RUN, PROG). Define run_cond = `upg_rst_i` | `upg_done_i`, sampled each edge.
  - RUN -> PROG when run_cond=0. This clears `upg_cnt_o`.
  - PROG -> RUN when run_cond=1. `upg_cnt_o` holds its value.
  - `kickoff_o` is the FSM state register.
- RUN:
  - The array port is owned by the CPU; `upg_wen_i` is ignored.
  - An access is accepted on any edge with `mem_req_i`=1.
- PROG:
  - The array port is owned by UPG. `upg_wen_i`=1 writes `upg_data_i` to word `upg_addr_i` and increments `upg_cnt_o`.
  - CPU requests are not accepted and produce no `mem_valid_o`.
- Alignment:
  - Half accesses require `mem_addr_i[0]`=0; word accesses require [1:0]=0; byte accesses are always aligned.
  - A misaligned access performs no array write, leaves `mem_rdata_o` unchanged, and completes with `mem_valid_o`=1 and `mem_misalign_o`=1.
- Store (little-endian):
  - Byte: writes lane [1:0] only.
  - Half: writes lanes {addr[1],0} and {addr[1],1}.
  - Word: writes all four lanes.
  - Unwritten lanes are preserved; no read-modify-write cycle is used (per-lane byte write enables).
- Load:
  - Reads word addr[ADDR_W+1:2], then selects the byte or half-word lane.
  - Extends to 32 bits per `mem_unsigned_i`; word loads ignore `mem_unsigned_i`.
- Request attributes (size, unsigned, lane, we) are registered at acceptance for use in the completion cycle.

## Timing
- Access accepted at edge N -> `mem_valid_o`=1 during cycle N+1 (after edge N+1 is not required; valid is the registered pulse following edge N).
- For loads, `mem_rdata_o` updates in the same cycle as `mem_valid_o`.
- Fully pipelined: one access per cycle with no bubbles, and one completion per accepted request, in order.
- Store at N followed by load of the same word at N+1: the load returns the new data.
- Mode change is effective the cycle after the edge that samples run_cond.
  - A request accepted on the last RUN edge still completes at N+1, even if the FSM is in PROG by then.
  - The first UPG write is honoured on the first edge where `kickoff_o`=0.
- `upg_wen_i` on the same edge as the PROG -> RUN transition is still written, because the FSM was in PROG at that edge.
- `mem_ready_o` is derived combinationally from `kickoff_o` only.
- `upg_cnt_o` saturates at 2^(ADDR_W+1)-1; it does not wrap.

## Test plan
- Reset with BOOT_RUN=0, then hold `upg_rst_i`=0 and `upg_done_i`=0:
  - Expect `kickoff_o`=0, `mem_ready_o`=0.
  - Write 0x11111111, 0x22222222, 0x33333333 to words 0, 1, 2 -> `upg_cnt_o`=3.
  - Raise `upg_done_i` -> `kickoff_o`=1 the next cycle.
- RUN: load word at byte address 0x8 -> one cycle later `mem_valid_o`=1, `mem_rdata_o`=0x33333333.
- Sub-word access:
  - sw 0x00000000 to 0x10, then sb 0x80 to 0x11.
  - lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0x00008000.
  - sh 0xBEEF to 0x12, then lh 0x12 -> 0xFFFFBEEF.
- Misalignment: lh at 0x11 and sw at 0x12 -> both give `mem_misalign_o`=1, `mem_rdata_o` unchanged; lw 0x10 afterwards still returns 0xBEEF8000.
- Back-to-back: sw 0xCAFEF00D to 0x20 at N, lw 0x20 at N+1 -> valid pulses at N+1 and N+2, and the load returns 0xCAFEF00D.
- Reset and mode-switch corner cases:
  - Drop `upg_rst_i` on the same edge a lw is accepted -> the lw still completes with valid; `mem_ready_o`=0 the next cycle; `upg_cnt_o`=0.
  - Assert `rst_n`=0 mid-stream -> outputs return to their reset values immediately.
